register_status_table: RTL and testbench

// - Rename-stage alias table: for each architectural register, holds busy bit + ROB entry of youngest in-flight writer.
// - Sits directly upstream of the ROB rename value buffer: rob1/rob2 from this block index that buffer,

---
 rtl/rename_pkg.sv | 14 +
 rtl/rst_entry.sv | 32 +++
 rtl/register_status_table.sv | 58 +++++
 tb/tb_register_status_table.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage types: ROB tag and architectural register index.
// Also used by the rename value buffer and the ROB.
package rename_pkg;

  localparam int ROB   = 2;
  localparam int RIDX  = 4;
  localparam int REGS  = 32;
  localparam int ROB_W = ROB + 1;
  localparam int REG_W = RIDX + 1;

  typedef logic [ROB_W-1:0] rob_tag_t;
  typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/rst_entry.sv
// One alias-table entry: busy flag plus ROB tag of the youngest in-flight writer.
// Priority is flush over rename (set) over tag-matched commit (clear).
module rst_entry
  import rename_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  input  logic     flush,
  input  logic     set,
  input  rob_tag_t set_tag,
  input  logic     clr,
  input  rob_tag_t clr_tag,
  output logic     busy,
  output rob_tag_t tag
);

  // Flush leaves the tag alone; only busy is dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      tag  <= '0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (set) begin
      busy <= 1'b1;
      tag  <= set_tag;
    end else if (clr && (tag == clr_tag)) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/register_status_table.sv
// Rename-stage alias table: per-register busy bit and producer ROB tag,
// with zero-latency source lookups from pre-edge state.
module register_status_table
  import rename_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rd,
  input  logic     renameEn,
  input  rob_tag_t robAlloc,
  input  logic     wcommit,
  input  reg_idx_t commitRd,
  input  rob_tag_t ROBcommit,
  input  logic     flush,
  output logic     busy1,
  output logic     busy2,
  output rob_tag_t rob1,
  output rob_tag_t rob2
);

  logic [REGS-1:0] busy_vec;
  rob_tag_t        tag_vec [REGS];

  // x0 has no storage; it reads as permanently idle with tag 0
  assign busy_vec[0] = 1'b0;
  assign tag_vec[0]  = '0;

  for (genvar i = 1; i < REGS; i++) begin : g_entry
    logic rename_hit;
    logic commit_hit;

    assign rename_hit = renameEn && (rd == reg_idx_t'(i));
    assign commit_hit = wcommit && (commitRd == reg_idx_t'(i));

    rst_entry u_entry (
      .clk     (clk),
      .resetn  (resetn),
      .flush   (flush),
      .set     (rename_hit),
      .set_tag (robAlloc),
      .clr     (commit_hit),
      .clr_tag (ROBcommit),
      .busy    (busy_vec[i]),
      .tag     (tag_vec[i])
    );
  end

  // No bypass of same-cycle rename or commit: lookups see registered state only
  always_comb begin
    busy1 = busy_vec[rs1];
    rob1  = tag_vec[rs1];
    busy2 = busy_vec[rs2];
    rob2  = tag_vec[rs2];
  end

endmodule

// File: tb/tb_register_status_table.sv
// Bench for register_status_table: directed vector table, async-reset sequence,
// and randomized traffic checked against an array-based reference model.
module tb_register_status_table;
  import rename_pkg::*;

  logic     clk = 1'b0;
  logic     resetn;
  reg_idx_t rs1, rs2, rd, commitRd;
  logic     renameEn, wcommit, flush;
  rob_tag_t robAlloc, ROBcommit;
  logic     busy1, busy2;
  rob_tag_t rob1, rob2;

  int checks = 0;
  int errors = 0;

  logic     busy_m [REGS];
  rob_tag_t tag_m  [REGS];

  typedef struct {
    reg_idx_t s1;
    reg_idx_t s2;
    reg_idx_t d;
    logic     ren;
    rob_tag_t alloc;
    logic     wc;
    reg_idx_t crd;
    rob_tag_t ctag;
    logic     fl;
    logic     b1;
    rob_tag_t r1;
    logic     b2;
    rob_tag_t r2;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  register_status_table dut (
    .clk       (clk),
    .resetn    (resetn),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .renameEn  (renameEn),
    .robAlloc  (robAlloc),
    .wcommit   (wcommit),
    .commitRd  (commitRd),
    .ROBcommit (ROBcommit),
    .flush     (flush),
    .busy1     (busy1),
    .busy2     (busy2),
    .rob1      (rob1),
    .rob2      (rob2)
  );

  function automatic vec_t mk(int s1, int s2, int ren, int d, int alloc, int wc, int crd,
                              int ctag, int fl, int b1, int r1, int b2, int r2);
    vec_t v;
    v.s1 = reg_idx_t'(s1);  v.s2 = reg_idx_t'(s2);
    v.ren = 1'(ren);        v.d = reg_idx_t'(d);   v.alloc = rob_tag_t'(alloc);
    v.wc = 1'(wc);          v.crd = reg_idx_t'(crd); v.ctag = rob_tag_t'(ctag);
    v.fl = 1'(fl);
    v.b1 = 1'(b1);          v.r1 = rob_tag_t'(r1);
    v.b2 = 1'(b2);          v.r2 = rob_tag_t'(r2);
    return v;
  endfunction

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_output(string name, logic b1, rob_tag_t r1, logic b2, rob_tag_t r2);
    check_val({name, ".busy1"}, int'(busy1), int'(b1));
    check_val({name, ".rob1"},  int'(rob1),  int'(r1));
    check_val({name, ".busy2"}, int'(busy2), int'(b2));
    check_val({name, ".rob2"},  int'(rob2),  int'(r2));
  endtask

  task automatic check_model(string name);
    check_output(name, (rs1 == 0) ? 1'b0 : busy_m[rs1], (rs1 == 0) ? rob_tag_t'(0) : tag_m[rs1],
                       (rs2 == 0) ? 1'b0 : busy_m[rs2], (rs2 == 0) ? rob_tag_t'(0) : tag_m[rs2]);
  endtask

  task automatic model_reset();
    for (int r = 0; r < REGS; r++) begin
      busy_m[r] = 1'b0;
      tag_m[r]  = '0;
    end
  endtask

  // Commit only releases when the committing tag still owns the register;
  // a same-cycle rename then re-claims it; flush discards both updates
  task automatic model_update();
    if (flush) begin
      for (int r = 0; r < REGS; r++) busy_m[r] = 1'b0;
    end else begin
      if (wcommit && commitRd != 0 && tag_m[commitRd] == ROBcommit) busy_m[commitRd] = 1'b0;
      if (renameEn && rd != 0) begin
        busy_m[rd] = 1'b1;
        tag_m[rd]  = robAlloc;
      end
    end
  endtask

  task automatic clock_cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(vec_t v);
    rs1 = v.s1; rs2 = v.s2;
    renameEn = v.ren; rd = v.d; robAlloc = v.alloc;
    wcommit = v.wc; commitRd = v.crd; ROBcommit = v.ctag;
    flush = v.fl;
  endtask

  task automatic clear_inputs();
    rs1 = '0; rs2 = '0; rd = '0; commitRd = '0;
    renameEn = 1'b0; wcommit = 1'b0; flush = 1'b0;
    robAlloc = '0; ROBcommit = '0;
  endtask

  initial begin
    //              s1 s2 ren rd al wc crd ct fl  b1 r1 b2 r2
    vecs[0]  = mk( 5, 6, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk( 5, 5, 1, 5, 3, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[2]  = mk( 5, 0, 1, 5, 6, 0, 0, 0, 0,  1, 3, 0, 0);
    vecs[3]  = mk( 5, 0, 0, 0, 0, 1, 5, 3, 0,  1, 6, 0, 0);
    vecs[4]  = mk( 5, 0, 0, 0, 0, 1, 5, 6, 0,  1, 6, 0, 0);
    vecs[5]  = mk( 5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 6, 0, 0);
    vecs[6]  = mk( 7, 0, 1, 7, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[7]  = mk( 7, 0, 1, 7, 2, 1, 7, 1, 0,  1, 1, 0, 0);
    vecs[8]  = mk( 7, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0);
    vecs[9]  = mk( 3, 9, 1, 3, 4, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[10] = mk( 3, 9, 1, 9, 5, 0, 0, 0, 0,  1, 4, 0, 0);
    vecs[11] = mk( 9,12, 1,12, 7, 0, 0, 0, 0,  1, 5, 0, 0);
    vecs[12] = mk( 3,12, 1, 4, 1, 0, 0, 0, 1,  1, 4, 1, 7);
    vecs[13] = mk( 4,12, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 7);
    vecs[14] = mk( 3, 9, 0, 0, 0, 0, 0, 0, 0,  0, 4, 0, 5);
    vecs[15] = mk( 0, 0, 1, 0, 3, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[16] = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    resetn = 1'b0;
    clear_inputs();
    rs1 = 5'd5; rs2 = 5'd6;
    #2;
    check_output("reset", 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d", i), vecs[i].b1, vecs[i].r1, vecs[i].b2, vecs[i].r2);
      clock_cycle();
    end

    // Asynchronous reset asserted between edges with x8 busy
    model_reset();
    clear_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    renameEn = 1'b1; rd = 5'd8; robAlloc = 3'd5;
    clock_cycle();
    renameEn = 1'b0; rs1 = 5'd8;
    #1;
    check_val("pre_reset.busy1", int'(busy1), 1);
    check_val("pre_reset.rob1",  int'(rob1),  5);
    #2;
    resetn = 1'b0;
    #1;
    check_val("async_reset.busy1", int'(busy1), 0);
    check_val("async_reset.rob1",  int'(rob1),  0);
    renameEn = 1'b1; robAlloc = 3'd6;
    @(posedge clk);
    @(negedge clk);
    check_val("held_reset.busy1", int'(busy1), 0);
    renameEn = 1'b0;
    resetn = 1'b1;
    model_reset();
    #1;
    check_val("post_reset.busy1", int'(busy1), 0);
    @(negedge clk);

    // Random traffic over a small register window to force collisions
    for (int n = 0; n < 600; n++) begin
      rs1 = reg_idx_t'($urandom_range(0, 9));
      rs2 = reg_idx_t'($urandom_range(0, 9));
      renameEn = 1'($urandom_range(0, 99) < 60);
      rd = reg_idx_t'($urandom_range(0, 9));
      robAlloc = rob_tag_t'($urandom);
      wcommit = 1'($urandom_range(0, 99) < 50);
      commitRd = reg_idx_t'($urandom_range(0, 9));
      ROBcommit = ($urandom_range(0, 1) == 1) ? tag_m[commitRd] : rob_tag_t'($urandom);
      flush = 1'($urandom_range(0, 99) < 4);
      #1;
      check_model($sformatf("rand%0d", n));
      clock_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
